instr_fetch_ctrl: RTL and testbench



---
 rtl/instr_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - byte-serial instruction fetch sequencer with output queue
// Assembles four big-endian bytes per word and hands words to the core over valid/ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter int          MEM_LIMIT = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_adr,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        busy
);

  localparam int          PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [31:0] RESET_FPC = {RESET_PC[31:2], 2'b00};
  localparam logic [32:0] LIMIT     = 33'(MEM_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fpc, w_fpc_nxt;
  logic [1:0]  r_bcnt, w_bcnt_nxt;
  logic [23:0] r_lanes, w_lanes_nxt;

  logic [31:0] r_qdata [QDEPTH];
  logic [31:0] r_qpc   [QDEPTH];
  logic        r_qerr  [QDEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [2:0]  r_count;

  logic        w_has, w_pop, w_space, w_oor, w_active;
  logic        w_push, w_push_err;
  logic [31:0] w_push_data;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_has   = (r_count != 3'd0);
  assign w_pop   = w_has && inst_ready;
  assign w_space = (r_count < 3'(QDEPTH)) || w_pop;
  assign w_oor   = ({1'b0, r_fpc} + 33'd3) > LIMIT;
  // A new word only starts with en high; a word already in progress always finishes.
  assign w_active = ((r_state == S_FETCH) && ((r_bcnt != 2'd0) || en)) ||
                    ((r_state == S_IDLE) && en);

  assign mem_adr    = r_fpc + {30'd0, r_bcnt};
  assign inst_valid = w_has;
  assign inst_data  = w_has ? r_qdata[r_head] : 32'd0;
  assign inst_pc    = w_has ? r_qpc[r_head]   : 32'd0;
  assign inst_err   = w_has ? r_qerr[r_head]  : 1'b0;
  assign busy       = (r_state == S_FETCH) || w_has;

  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_bcnt_nxt  = r_bcnt;
    w_lanes_nxt = r_lanes;
    w_push      = 1'b0;
    w_push_err  = 1'b0;
    w_push_data = 32'd0;
    if (r_state != S_HALT) begin
      if (!w_active) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_FETCH;
        if (w_space) begin
          if ((r_bcnt == 2'd0) && w_oor) begin
            w_push      = 1'b1;
            w_push_err  = 1'b1;
            w_state_nxt = S_HALT;
          end else if (r_bcnt == 2'd3) begin
            w_push      = 1'b1;
            w_push_data = {r_lanes, mem_rdata};
            w_fpc_nxt   = r_fpc + 32'd4;
            w_bcnt_nxt  = 2'd0;
            w_state_nxt = en ? S_FETCH : S_IDLE;
          end else begin
            case (r_bcnt)
              2'd0:    w_lanes_nxt[23:16] = mem_rdata;
              2'd1:    w_lanes_nxt[15:8]  = mem_rdata;
              default: w_lanes_nxt[7:0]   = mem_rdata;
            endcase
            w_bcnt_nxt = r_bcnt + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_FPC;
      r_bcnt  <= 2'd0;
      r_lanes <= 24'd0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 3'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_qdata[i] <= 32'd0;
        r_qpc[i]   <= 32'd0;
        r_qerr[i]  <= 1'b0;
      end
    end else if (redirect) begin
      r_state <= en ? S_FETCH : S_IDLE;
      r_fpc   <= redirect_pc & 32'hFFFF_FFFC;
      r_bcnt  <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_lanes <= w_lanes_nxt;
      if (w_push) begin
        r_qdata[r_tail] <= w_push_data;
        r_qpc[r_tail]   <= r_fpc;
        r_qerr[r_tail]  <= w_push_err;
        r_tail          <= f_inc(r_tail);
      end
      if (w_pop) r_head <= f_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl
// Expected words come from the fetch-address sequence after each reset/redirect.
module tb_instr_fetch_ctrl;

  localparam int LIM = 2000;

  logic        clk = 1'b0;
  logic        rst, en, redirect, inst_ready;
  logic [31:0] redirect_pc, mem_adr, inst_data, inst_pc;
  logic [7:0]  mem_rdata;
  logic        inst_valid, inst_err, busy;

  logic [7:0] mem [0:2047];

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(2), .MEM_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_adr(mem_adr), .mem_rdata(mem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_err(inst_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_adr < 32'd2048) ? mem[mem_adr[10:0]] : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Every fetch restart yields words start, start+4, ... until the first out-of-range word.
  task automatic refill(input logic [31:0] start);
    longint p;
    exp_t   e;
    exp_q.delete();
    p = longint'(start & 32'hFFFF_FFFC);
    for (int i = 0; i < 600; i++) begin
      if (p + 3 > LIM) begin
        e.data = 32'd0; e.pc = p[31:0]; e.err = 1'b1;
        exp_q.push_back(e);
        break;
      end
      e.data = {mem[p], mem[p+1], mem[p+2], mem[p+3]};
      e.pc   = p[31:0];
      e.err  = 1'b0;
      exp_q.push_back(e);
      p += 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hold_v = 1'b0;
  exp_t hold_e;

  always @(negedge clk) begin
    exp_t e;
    if (rst || redirect) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_data", inst_data, hold_e.data);
        chk("hold_pc", inst_pc, hold_e.pc);
        chk("hold_err", inst_err, hold_e.err);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got pc %h data %h expected none", inst_pc, inst_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", inst_data, e.data);
          chk("pop_pc", inst_pc, e.pc);
          chk("pop_err", inst_err, e.err);
        end
      end
      hold_v = inst_valid && !inst_ready;
      hold_e.data = inst_data;
      hold_e.pc   = inst_pc;
      hold_e.err  = inst_err;
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    refill(pc);
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[4] = 8'hA0; mem[5] = 8'hB0; mem[6] = 8'hC0; mem[7] = 8'hD0;
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_err", inst_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adr", mem_adr, 0);

    refill(32'd0);
    en = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("adr_seq", mem_adr, k);
      chk("early_valid", inst_valid, 0);
    end
    tick();
    chk("first_valid", inst_valid, 1);
    chk("first_data", inst_data, 32'h0102_0304);
    chk("first_pc", inst_pc, 0);
    chk("adr_after_word", mem_adr, 4);
    repeat (16) tick();
    chk("full_adr_frozen", mem_adr, 8);
    chk("full_head_data", inst_data, 32'h0102_0304);
    chk("full_busy", busy, 1);
    inst_ready = 1'b1;
    repeat (12) tick();

    do_redirect(32'h4);
    tick(); tick();
    chk("redir_mid_adr", mem_adr, 6);
    do_redirect(32'h13);
    chk("redir_valid", inst_valid, 0);
    chk("redir_adr", mem_adr, 32'h10);
    repeat (8) tick();

    do_redirect(32'd1996);
    repeat (12) tick();
    chk("halt_adr", mem_adr, 2000);
    chk("halt_valid", inst_valid, 0);
    chk("halt_busy", busy, 0);
    repeat (5) tick();
    chk("halt_adr_hold", mem_adr, 2000);

    do_redirect(32'h20);
    tick();
    chk("enfall_adr", mem_adr, 32'h21);
    en = 1'b0;
    inst_ready = 1'b0;
    repeat (3) tick();
    chk("enfall_valid", inst_valid, 1);
    chk("enfall_busy", busy, 1);
    chk("enfall_adr_done", mem_adr, 32'h24);
    repeat (3) tick();
    chk("idle_adr", mem_adr, 32'h24);
    chk("idle_busy_q", busy, 1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("drained_valid", inst_valid, 0);
    chk("drained_busy", busy, 0);

    en = 1'b1;
    do_redirect(32'h40);
    repeat (12) tick();
    chk("full_before_rst", inst_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_data", inst_data, 0);
    chk("arst_pc", inst_pc, 0);
    chk("arst_err", inst_err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_adr", mem_adr, 0);
    refill(32'd0);
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    repeat (12) tick();

    for (int c = 0; c < 3000; c++) begin
      en = ($urandom % 8) != 0;
      inst_ready = $urandom % 2;
      if (($urandom % 40) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom % 2048;
        refill(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    en = 1'b0;
    inst_ready = 1'b1;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
